seg_scan_display: RTL and testbench

- Response end of the CPU-to-display interface: the CPU FSM drives a value plus three status flags (busy, inp_take, pc_disp), and this block renders them.
- It converts the 8-bit value to three decimal digits with a sequential double-dabble converter and shows them on a 4-digit multiplexed seven-segment display.
- Digit 1 carries a mode glyph; the 8 discrete LEDs mirror the value.
- Sits directly under the top-level CPU FSM, alongside the memories and adder.

---
 rtl/seg_pkg.sv | 57 +++++
 rtl/bin2bcd_seq.sv | 74 +++++++
 rtl/seg_scan_display.sv | 132 +++++++++++++
 tb/tb_seg_scan_display.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
//------------------------------------------------------------------------------
// Module   : seg_pkg
// Purpose  : Shared segment codes, digit index type and converter states for
//            the seven-segment scan display.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

    // Segment order {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_I     = 7'b1001111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    function automatic logic [6:0] seg_digit(input logic [3:0] v);
        case (v)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] dd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
//------------------------------------------------------------------------------
// Module   : bin2bcd_seq
// Purpose  : Sequential 8-bit double-dabble converter; the BCD outputs form
//            the display register and change only on completion.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bin,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] units
);

    conv_state_t r_state;
    logic [7:0]  r_bin;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;
    logic [10:0] w_adj;

    // Hundreds never reaches 5 for an 8-bit input, so only tens/units adjust
    assign w_adj = {r_bcd[10:8], dd_adjust(r_bcd[7:4]), dd_adjust(r_bcd[3:0])};

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            hund    <= '0;
            tens    <= '0;
            units   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin   <= bin;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd <= {w_adj, r_bin[7]};
                    r_bin <= {r_bin[6:0], 1'b0};
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7)
                        r_state <= DONE;
                end
                DONE: begin
                    hund    <= r_bcd[11:8];
                    tens    <= r_bcd[7:4];
                    units   <= r_bcd[3:0];
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan_display.sv
//------------------------------------------------------------------------------
// Module   : seg_scan_display
// Purpose  : Renders an 8-bit value as three decimal digits plus a mode glyph
//            on a 4-digit multiplexed display. Option: LEADING_ZERO_BLANK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_display
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 12500000
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] inp,
    input  logic       busy,
    input  logic       inp_take,
    input  logic       pc_disp,
    output logic [6:0] led,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic       d4,
    output logic [7:0] s_led
);

    localparam int c_scan_w  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_blink_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(REFRESH_DIV - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);

    logic [7:0]           r_last;
    logic [7:0]           r_pending;
    logic [c_scan_w-1:0]  r_scan_cnt;
    logic [c_blink_w-1:0] r_blink_cnt;
    digit_idx_t           r_idx;
    logic                 r_phase;
    logic [6:0]           r_glyph;

    logic       w_start, w_conv_busy, w_conv_done;
    logic [3:0] w_hund, w_tens, w_units;
    logic       w_scan_wrap, w_blink_wrap, w_phase_nxt;
    digit_idx_t w_idx_nxt;
    logic [6:0] w_glyph_now, w_glyph_nxt, w_seg;
    logic       w_hund_blank, w_tens_blank;

    assign w_start = (inp != r_last);

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .bin   (inp),
        .start (w_start),
        .busy  (w_conv_busy),
        .done  (w_conv_done),
        .hund  (w_hund),
        .tens  (w_tens),
        .units (w_units)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign w_hund_blank = (w_hund == 4'd0);
    assign w_tens_blank = w_hund_blank && (w_tens == 4'd0);
`else
    assign w_hund_blank = 1'b0;
    assign w_tens_blank = 1'b0;
`endif

    assign w_scan_wrap  = (r_scan_cnt == c_scan_last);
    assign w_idx_nxt    = w_scan_wrap ? digit_idx_t'(r_idx + 2'd1) : r_idx;
    assign w_blink_wrap = (r_blink_cnt == c_blink_last);
    assign w_phase_nxt  = !inp_take ? 1'b1 : (w_blink_wrap ? ~r_phase : r_phase);

    always_comb begin
        w_glyph_now = SEG_BLANK;
        if (inp_take)
            w_glyph_now = SEG_I;
        else if (pc_disp)
            w_glyph_now = SEG_P;
        else if (busy)
            w_glyph_now = SEG_B;
    end

    // Glyph is latched on entry to the digit-1 slot so it never changes mid-slot
    assign w_glyph_nxt = (w_scan_wrap && (w_idx_nxt == 2'd0)) ? w_glyph_now : r_glyph;

    always_comb begin
        w_seg = SEG_BLANK;
        case (w_idx_nxt)
            2'd0: w_seg = w_glyph_nxt;
            2'd1: w_seg = w_hund_blank ? SEG_BLANK : seg_digit(w_hund);
            2'd2: w_seg = w_tens_blank ? SEG_BLANK : seg_digit(w_tens);
            2'd3: w_seg = seg_digit(w_units);
            default: w_seg = SEG_BLANK;
        endcase
        if (!w_phase_nxt)
            w_seg = SEG_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last           <= '0;
            r_pending        <= '0;
            s_led            <= '0;
            r_scan_cnt       <= '0;
            r_idx            <= '0;
            r_blink_cnt      <= '0;
            r_phase          <= 1'b1;
            r_glyph          <= SEG_BLANK;
            led              <= SEG_BLANK;
            {d1, d2, d3, d4} <= 4'hF;
        end else begin
            s_led <= inp;
            if (w_start && !w_conv_busy)
                r_pending <= inp;
            if (w_conv_done)
                r_last <= r_pending;
            r_scan_cnt  <= w_scan_wrap ? '0 : r_scan_cnt + c_scan_w'(1);
            r_idx       <= w_idx_nxt;
            r_blink_cnt <= (!inp_take || w_blink_wrap) ? '0 : r_blink_cnt + c_blink_w'(1);
            r_phase     <= w_phase_nxt;
            r_glyph     <= w_glyph_nxt;
            led         <= w_seg;
            {d1, d2, d3, d4} <= ~(4'b1000 >> w_idx_nxt);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_display.sv
//------------------------------------------------------------------------------
// Module   : tb_seg_scan_display
// Purpose  : Directed self-checking bench for seg_scan_display.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_seg_scan_display;

    localparam int REFRESH_DIV = 4;
    localparam int BLINK_DIV   = 8;

    localparam logic [6:0] E_0 = 7'b1000000;
    localparam logic [6:0] E_1 = 7'b1111001;
    localparam logic [6:0] E_2 = 7'b0100100;
    localparam logic [6:0] E_3 = 7'b0110000;
    localparam logic [6:0] E_5 = 7'b0010010;
    localparam logic [6:0] E_7 = 7'b1111000;
    localparam logic [6:0] E_9 = 7'b0010000;
    localparam logic [6:0] E_I = 7'b1001111;
    localparam logic [6:0] E_P = 7'b0001100;
    localparam logic [6:0] E_BLANK = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] E_LZ = 7'h7F;
`else
    localparam logic [6:0] E_LZ = 7'b1000000;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] inp = 8'd0;
    logic       busy = 1'b0;
    logic       inp_take = 1'b0;
    logic       pc_disp = 1'b0;
    logic [6:0] led;
    logic       d1, d2, d3, d4;
    logic [7:0] s_led;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seg_scan_display #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inp      (inp),
        .busy     (busy),
        .inp_take (inp_take),
        .pc_disp  (pc_disp),
        .led      (led),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .d4       (d4),
        .s_led    (s_led)
    );

    // Waits for a fresh entry into digit slot k (0 = d1) and samples led there;
    // ok is cleared on timeout or when the enables are not exactly one-hot.
    task automatic get_slot(input int k, output logic [6:0] seg, output bit ok);
        logic [3:0] en;
        ok  = 1'b0;
        seg = 7'h00;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            en = {d1, d2, d3, d4};
            if (en[3-k]) break;
        end
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            en = {d1, d2, d3, d4};
            if (!en[3-k]) begin
                seg = led;
                ok  = (en == ~(4'b1000 >> k));
                return;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] seg;
        bit         ok;
        logic [6:0] exp_s [3];
        exp_s[0] = E_LZ; exp_s[1] = E_LZ; exp_s[2] = E_0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (led !== E_BLANK) $display("FAIL reset_led: got %h expected %h", led, E_BLANK);
        else passed++;
        checks++;
        if ({d1, d2, d3, d4} !== 4'hF) $display("FAIL reset_digits: got %b expected 1111", {d1, d2, d3, d4});
        else passed++;
        checks++;
        if (s_led !== 8'h00) $display("FAIL reset_s_led: got %h expected 00", s_led);
        else passed++;
        rst_n = 1'b1;
        for (int k = 1; k < 4; k++) begin
            get_slot(k, seg, ok);
            checks++;
            if (!ok || seg !== exp_s[k-1]) $display("FAIL reset_zero_slot%0d: got %h ok=%0d expected %h", k, seg, ok, exp_s[k-1]);
            else passed++;
        end
    endtask

    task automatic test_convert();
        logic [6:0] seg;
        bit         ok;
        logic [6:0] exp_s [3];
        exp_s[0] = E_1; exp_s[1] = E_7; exp_s[2] = E_3;
        @(negedge clk);
        inp = 8'd173;
        @(negedge clk);
        checks++;
        if (s_led !== 8'hAD) $display("FAIL s_led_latency: got %h expected ad", s_led);
        else passed++;
        repeat (8) @(negedge clk);
        checks++;
        if ({dut.u_bcd.hund, dut.u_bcd.tens, dut.u_bcd.units} !== 12'h000)
            $display("FAIL conv_early: got %h expected 000", {dut.u_bcd.hund, dut.u_bcd.tens, dut.u_bcd.units});
        else passed++;
        @(negedge clk);
        checks++;
        if ({dut.u_bcd.hund, dut.u_bcd.tens, dut.u_bcd.units} !== 12'h173)
            $display("FAIL conv_173: got %h expected 173", {dut.u_bcd.hund, dut.u_bcd.tens, dut.u_bcd.units});
        else passed++;
        for (int k = 1; k < 4; k++) begin
            get_slot(k, seg, ok);
            checks++;
            if (!ok || seg !== exp_s[k-1]) $display("FAIL scan_173_slot%0d: got %h ok=%0d expected %h", k, seg, ok, exp_s[k-1]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] seg;
        bit         ok;
        @(negedge clk);
        inp = 8'd255;
        repeat (4) @(negedge clk);
        inp = 8'd9;
        repeat (6) @(negedge clk);
        checks++;
        if ({dut.u_bcd.hund, dut.u_bcd.tens, dut.u_bcd.units} !== 12'h255)
            $display("FAIL b2b_first: got %h expected 255", {dut.u_bcd.hund, dut.u_bcd.tens, dut.u_bcd.units});
        else passed++;
        repeat (10) @(negedge clk);
        checks++;
        if ({dut.u_bcd.hund, dut.u_bcd.tens, dut.u_bcd.units} !== 12'h009)
            $display("FAIL b2b_second: got %h expected 009", {dut.u_bcd.hund, dut.u_bcd.tens, dut.u_bcd.units});
        else passed++;
        get_slot(3, seg, ok);
        checks++;
        if (!ok || seg !== E_9) $display("FAIL b2b_units: got %h ok=%0d expected %h", seg, ok, E_9);
        else passed++;
    endtask

    task automatic test_glyph();
        logic [6:0] seg;
        bit         ok;
        inp     = 8'd200;
        pc_disp = 1'b1;
        busy    = 1'b1;
        get_slot(0, seg, ok);
        checks++;
        if (!ok || seg !== E_P) $display("FAIL glyph_p: got %h ok=%0d expected %h", seg, ok, E_P);
        else passed++;
        // Raise inp_take at the start of the units slot so the next d1 slot is in the on phase
        get_slot(3, seg, ok);
        inp_take = 1'b1;
        get_slot(0, seg, ok);
        checks++;
        if (!ok || seg !== E_I) $display("FAIL glyph_i: got %h ok=%0d expected %h", seg, ok, E_I);
        else passed++;
        inp_take = 1'b0;
        pc_disp  = 1'b0;
        busy     = 1'b0;
        get_slot(0, seg, ok);
        checks++;
        if (!ok || seg !== E_BLANK) $display("FAIL glyph_none: got %h ok=%0d expected %h", seg, ok, E_BLANK);
        else passed++;
    endtask

    task automatic test_blink();
        logic [6:0] seg;
        bit         ok;
        bit         exp_off;
        pc_disp = 1'b1;
        get_slot(0, seg, ok);
        checks++;
        if (!ok || seg !== E_P) $display("FAIL blink_pre_glyph: got %h ok=%0d expected %h", seg, ok, E_P);
        else passed++;
        inp_take = 1'b1;
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            exp_off = ((i / 8) % 2) == 1;
            checks++;
            if ((led === E_BLANK) !== exp_off)
                $display("FAIL blink_cycle%0d: got led %h expected off=%0d", i, led, exp_off);
            else passed++;
        end
        inp_take = 1'b0;
        @(negedge clk);
        checks++;
        if (led === E_BLANK) $display("FAIL blink_release: got %h expected lit", led);
        else passed++;
        pc_disp = 1'b0;
    endtask

    task automatic test_leading_zero();
        logic [6:0] seg;
        bit         ok;
        logic [6:0] exp_s [3];
        @(negedge clk);
        inp = 8'd5;
        repeat (12) @(negedge clk);
        exp_s[0] = E_LZ; exp_s[1] = E_LZ; exp_s[2] = E_5;
        for (int k = 1; k < 4; k++) begin
            get_slot(k, seg, ok);
            checks++;
            if (!ok || seg !== exp_s[k-1]) $display("FAIL lz5_slot%0d: got %h ok=%0d expected %h", k, seg, ok, exp_s[k-1]);
            else passed++;
        end
        inp = 8'd200;
        repeat (12) @(negedge clk);
        exp_s[0] = E_2; exp_s[1] = E_0; exp_s[2] = E_0;
        for (int k = 1; k < 4; k++) begin
            get_slot(k, seg, ok);
            checks++;
            if (!ok || seg !== exp_s[k-1]) $display("FAIL lz200_slot%0d: got %h ok=%0d expected %h", k, seg, ok, exp_s[k-1]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] seg;
        bit         ok;
        @(negedge clk);
        inp = 8'd99;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        inp   = 8'd0;
        #1;
        checks++;
        if (led !== E_BLANK) $display("FAIL midreset_led: got %h expected %h", led, E_BLANK);
        else passed++;
        checks++;
        if ({d1, d2, d3, d4} !== 4'hF) $display("FAIL midreset_digits: got %b expected 1111", {d1, d2, d3, d4});
        else passed++;
        checks++;
        if (s_led !== 8'h00) $display("FAIL midreset_s_led: got %h expected 00", s_led);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if ({dut.u_bcd.hund, dut.u_bcd.tens, dut.u_bcd.units} !== 12'h000)
            $display("FAIL midreset_bcd: got %h expected 000", {dut.u_bcd.hund, dut.u_bcd.tens, dut.u_bcd.units});
        else passed++;
        get_slot(3, seg, ok);
        checks++;
        if (!ok || seg !== E_0) $display("FAIL midreset_units: got %h ok=%0d expected %h", seg, ok, E_0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_convert();
        test_back_to_back();
        test_glyph();
        test_blink();
        test_leading_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
